// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall, flush and forwarding control with memory-wait FSM and event counters
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [4:0]  id_rf_ra0,
    input  logic [4:0]  id_rf_ra1,
    input  logic [4:0]  ex_rf_ra0,
    input  logic [4:0]  ex_rf_ra1,
    input  logic [4:0]  ex_rf_wa,
    input  logic        ex_rf_we,
    input  logic [1:0]  ex_rf_wd_sel,
    input  logic [4:0]  mem_rf_wa,
    input  logic        mem_rf_we,
    input  logic [1:0]  mem_rf_wd_sel,
    input  logic [4:0]  wb_rf_wa,
    input  logic        wb_rf_we,
    input  logic        ex_br_taken,
    input  logic        mem_dmem_req,
    input  logic        dmem_ready,
    output logic        stall_pc,
    output logic        stall_if_id,
    output logic        stall_id_ex,
    output logic        stall_ex_mem,
    output logic        stall_mem_wb,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        flush_ex_mem,
    output logic [1:0]  fwd0_sel,
    output logic [1:0]  fwd1_sel,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] MWAIT = 1'b1;
    localparam logic [1:0] WD_DMEM = 2'b10;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    logic [0:0] state;
    logic [0:0] state_nx;
    logic       mem_stall;
    logic       load_use;
    logic       lu_stall;
    logic       br_flush;

    // memory-wait FSM: leave IDLE on an unanswered request, return once the memory answers
    always_comb begin
        mem_stall = (state == IDLE) ? (mem_dmem_req & ~dmem_ready) : ~dmem_ready;
        state_nx  = (state == IDLE) ? ((mem_dmem_req & ~dmem_ready) ? MWAIT : IDLE)
                                    : (dmem_ready ? IDLE : MWAIT);
    end

    // FSM state register; runs regardless of en so a memory wait is never lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // hazard detection; a taken branch kills the dependent ID instruction, so it wins over load-use
    always_comb begin
        load_use = ex_rf_we & (ex_rf_wd_sel == WD_DMEM) & (ex_rf_wa != 5'd0) &
                   ((ex_rf_wa == id_rf_ra0) | (ex_rf_wa == id_rf_ra1));
        lu_stall = ~rst & ~mem_stall & load_use & ~ex_br_taken;
        br_flush = ~rst & ~mem_stall & ex_br_taken;
    end

    // stall/flush outputs; a memory wait freezes everything and defers any branch flush
    always_comb begin
        stall_pc     = (~rst & mem_stall) | lu_stall;
        stall_if_id  = (~rst & mem_stall) | lu_stall;
        stall_id_ex  = ~rst & mem_stall;
        stall_ex_mem = ~rst & mem_stall;
        stall_mem_wb = ~rst & mem_stall;
        flush_if_id  = br_flush;
        flush_id_ex  = br_flush | lu_stall;
        flush_ex_mem = 1'b0;
    end

    // operand forwarding: MEM (non-load) before WB, never for x0
    always_comb begin
        fwd0_sel = rst ? FWD_RF :
                   (mem_rf_we & (mem_rf_wa != 5'd0) & (mem_rf_wa == ex_rf_ra0) & (mem_rf_wd_sel != WD_DMEM)) ? FWD_MEM :
                   (wb_rf_we & (wb_rf_wa != 5'd0) & (wb_rf_wa == ex_rf_ra0)) ? FWD_WB : FWD_RF;
        fwd1_sel = rst ? FWD_RF :
                   (mem_rf_we & (mem_rf_wa != 5'd0) & (mem_rf_wa == ex_rf_ra1) & (mem_rf_wd_sel != WD_DMEM)) ? FWD_MEM :
                   (wb_rf_we & (wb_rf_wa != 5'd0) & (wb_rf_wa == ex_rf_ra1)) ? FWD_WB : FWD_RF;
    end

    // event counters, gated by en and wrapping naturally at 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            stall_cnt <= stall_cnt + {31'd0, en & stall_pc};
            flush_cnt <= flush_cnt + {31'd0, en & (flush_if_id | flush_id_ex)};
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed-vector self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst, en;
    logic [4:0]  id_rf_ra0, id_rf_ra1, ex_rf_ra0, ex_rf_ra1, ex_rf_wa, mem_rf_wa, wb_rf_wa;
    logic        ex_rf_we, mem_rf_we, wb_rf_we, ex_br_taken, mem_dmem_req, dmem_ready;
    logic [1:0]  ex_rf_wd_sel, mem_rf_wd_sel;
    logic        stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
    logic        flush_if_id, flush_id_ex, flush_ex_mem;
    logic [1:0]  fwd0_sel, fwd1_sel;
    logic [31:0] stall_cnt, flush_cnt;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_s, exp_f;

    hazard_ctrl dut (
        .clk(clk), .rst(rst), .en(en),
        .id_rf_ra0(id_rf_ra0), .id_rf_ra1(id_rf_ra1),
        .ex_rf_ra0(ex_rf_ra0), .ex_rf_ra1(ex_rf_ra1),
        .ex_rf_wa(ex_rf_wa), .ex_rf_we(ex_rf_we), .ex_rf_wd_sel(ex_rf_wd_sel),
        .mem_rf_wa(mem_rf_wa), .mem_rf_we(mem_rf_we), .mem_rf_wd_sel(mem_rf_wd_sel),
        .wb_rf_wa(wb_rf_wa), .wb_rf_we(wb_rf_we),
        .ex_br_taken(ex_br_taken), .mem_dmem_req(mem_dmem_req), .dmem_ready(dmem_ready),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
        .stall_ex_mem(stall_ex_mem), .stall_mem_wb(stall_mem_wb),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
        .fwd0_sel(fwd0_sel), .fwd1_sel(fwd1_sel),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] stalls();
        return {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb};
    endfunction

    function automatic logic [2:0] flushes();
        return {flush_if_id, flush_id_ex, flush_ex_mem};
    endfunction

    initial begin
        rst = 1'b1; en = 1'b1;
        id_rf_ra0 = 0; id_rf_ra1 = 0; ex_rf_ra0 = 0; ex_rf_ra1 = 0;
        ex_rf_wa = 0; ex_rf_we = 0; ex_rf_wd_sel = 0;
        mem_rf_wa = 0; mem_rf_we = 0; mem_rf_wd_sel = 0;
        wb_rf_wa = 0; wb_rf_we = 0;
        ex_br_taken = 0; mem_dmem_req = 0; dmem_ready = 0;
        exp_s = 0; exp_f = 0;
        tick(); tick();
        // hazards presented during reset must be masked
        ex_rf_wa = 5; ex_rf_we = 1; ex_rf_wd_sel = 2'b10; id_rf_ra1 = 5;
        mem_rf_wa = 7; mem_rf_we = 1; ex_rf_ra0 = 7;
        #1;
        chk("rst_stalls", {27'd0, stalls()}, 32'd0);
        chk("rst_flushes", {29'd0, flushes()}, 32'd0);
        chk("rst_fwd0", {30'd0, fwd0_sel}, 32'd0);
        chk("rst_scnt", stall_cnt, 32'd0);
        chk("rst_fcnt", flush_cnt, 32'd0);
        mem_rf_we = 0; ex_rf_ra0 = 0;
        rst = 1'b0;
        #1;
        // load-use on ra1
        chk("lu_stalls", {27'd0, stalls()}, 32'b11000);
        chk("lu_flushes", {29'd0, flushes()}, 32'b010);
        tick(); exp_s++; exp_f++;
        chk("lu_scnt", stall_cnt, exp_s);
        chk("lu_fcnt", flush_cnt, exp_f);
        ex_rf_we = 0; #1;
        chk("lu_gone", {27'd0, stalls()}, 32'd0);
        ex_rf_we = 1; ex_rf_wa = 0; id_rf_ra1 = 0; #1;
        chk("lu_x0", {27'd0, stalls()}, 32'd0);
        ex_rf_we = 0;
        // forwarding
        mem_rf_wa = 7; wb_rf_wa = 7; ex_rf_ra0 = 7; mem_rf_we = 1; wb_rf_we = 1; mem_rf_wd_sel = 2'b00; #1;
        chk("fwd_mem", {30'd0, fwd0_sel}, 32'd1);
        mem_rf_wd_sel = 2'b10; #1;
        chk("fwd_load_wb", {30'd0, fwd0_sel}, 32'd2);
        mem_rf_wd_sel = 2'b00; mem_rf_we = 0; #1;
        chk("fwd_wb", {30'd0, fwd0_sel}, 32'd2);
        ex_rf_ra1 = 7; mem_rf_we = 1; #1;
        chk("fwd1_mem", {30'd0, fwd1_sel}, 32'd1);
        ex_rf_ra0 = 0; #1;
        chk("fwd_x0", {30'd0, fwd0_sel}, 32'd0);
        mem_rf_we = 0; wb_rf_we = 0; #1;
        chk("fwd1_none", {30'd0, fwd1_sel}, 32'd0);
        tick();
        // 3-cycle memory wait
        mem_dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("mw_stall%0d", i), {27'd0, stalls()}, 32'b11111);
            tick(); exp_s++;
        end
        dmem_ready = 1; #1;
        chk("mw_release", {27'd0, stalls()}, 32'd0);
        tick();
        chk("mw_scnt", stall_cnt, exp_s);
        mem_dmem_req = 0; dmem_ready = 0; #1;
        chk("mw_idle", {27'd0, stalls()}, 32'd0);
        tick();
        // branch during 2-cycle memory wait
        mem_dmem_req = 1; dmem_ready = 0; ex_br_taken = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("bw_flush%0d", i), {29'd0, flushes()}, 32'd0);
            tick(); exp_s++;
        end
        dmem_ready = 1; #1;
        chk("bw_rel_flush", {29'd0, flushes()}, 32'b110);
        chk("bw_rel_stall", {27'd0, stalls()}, 32'd0);
        tick(); exp_f++;
        chk("bw_fcnt", flush_cnt, exp_f);
        chk("bw_scnt", stall_cnt, exp_s);
        mem_dmem_req = 0; dmem_ready = 0;
        // branch beats load-use
        ex_rf_wa = 5; ex_rf_we = 1; ex_rf_wd_sel = 2'b10; id_rf_ra0 = 5; #1;
        chk("sim_flush", {29'd0, flushes()}, 32'b110);
        chk("sim_stall_pc", {31'd0, stall_pc}, 32'd0);
        tick(); exp_f++;
        chk("sim_fcnt", flush_cnt, exp_f);
        // counters frozen with en=0
        ex_br_taken = 0; en = 0; #1;
        chk("en0_stall", {31'd0, stall_pc}, 32'd1);
        tick();
        chk("en0_scnt", stall_cnt, exp_s);
        chk("en0_fcnt", flush_cnt, exp_f);
        en = 1; ex_rf_we = 0;
        // reset in the middle of a memory wait
        mem_dmem_req = 1; dmem_ready = 0;
        tick(); tick();
        #2 rst = 1; #1;
        chk("rmw_scnt", stall_cnt, 32'd0);
        chk("rmw_fcnt", flush_cnt, 32'd0);
        chk("rmw_stalls", {27'd0, stalls()}, 32'd0);
        tick();
        mem_dmem_req = 0; rst = 0; #1;
        chk("rmw_idle", {27'd0, stalls()}, 32'd0);
        tick();
        chk("rmw_scnt2", stall_cnt, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
